stream_bitrev_reorder: RTL and testbench

- Streaming successor to the array-based FFT input reorder stage.
- Accepts one complex sample per cycle over a valid/ready handshake and buffers N-sample frames in a ping-pong (2×N) register memory.
- Emits each frame in bit-reversed order, or natural order in bypass mode.
- Sits between the sample source and the radix-2 FFT core; continuous back-to-back frames sustain full throughput.

---
 rtl/stream_bitrev_reorder_pkg.sv | 25 ++
 rtl/reorder_bank.sv | 63 ++++++
 rtl/stream_bitrev_reorder.sv | 124 ++++++++++++
 tb/tb_stream_bitrev_reorder.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_bitrev_reorder_pkg.sv
// Shared types and helpers for the streaming bit-reverse reorder stage.
// Holds the sample type, the bank state enum and a width-parameterised bitrev helper.
package stream_bitrev_reorder_pkg;

  typedef struct packed {
    logic signed [15:0] r;
    logic signed [15:0] i;
  } complex_product_t;

  typedef enum logic [1:0] {EMPTY, FILLING, FULL, DRAINING} bank_state_t;

  localparam int unsigned MaxIdxW = 16;

  // Reverses the low w bits of v; bits at and above w are returned as zero.
  function automatic logic [MaxIdxW-1:0] bitrev(input logic [MaxIdxW-1:0] v,
                                                input int unsigned w);
    logic [MaxIdxW-1:0] r;
    r = '0;
    for (int unsigned k = 0; k < MaxIdxW; k++) begin
      if (k < w) r[k] = v[w-1-k];
    end
    return r;
  endfunction

endpackage

// File: rtl/reorder_bank.sv
// One N-entry frame buffer of the ping-pong reorder memory: storage, bank state machine
// and the per-frame mode flag latched on the frame's first write.
module reorder_bank
  import stream_bitrev_reorder_pkg::*;
#(
  parameter int unsigned N = 16,
  localparam int unsigned LOG2N = $clog2(N)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic             wr_mode,
  input  logic [LOG2N-1:0] wr_cnt,
  input  complex_product_t wr_data,
  input  logic             rd_en,
  input  logic [LOG2N-1:0] rd_cnt,
  output bank_state_t      state,
  output bank_state_t      state_next,
  output logic             mode,
  output complex_product_t rd_data
);

  bank_state_t      state_q, state_d;
  logic             mode_q;
  logic             wr_mode_eff;
  logic [LOG2N-1:0] wr_addr;
  complex_product_t mem_q [N];

  // The first write of a frame already uses the incoming mode, before the flag is latched.
  assign wr_mode_eff = (wr_cnt == '0) ? wr_mode : mode_q;
  assign wr_addr     = wr_mode_eff ? LOG2N'(bitrev(MaxIdxW'(wr_cnt), LOG2N)) : wr_cnt;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      EMPTY:    if (wr_en) state_d = FILLING;
      FILLING:  if (wr_en && wr_cnt == LOG2N'(N-1)) state_d = FULL;
      FULL:     if (rd_en) state_d = DRAINING;
      DRAINING: if (rd_en && rd_cnt == LOG2N'(N-1)) state_d = EMPTY;
      default:  state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= EMPTY;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (wr_en && wr_cnt == '0) mode_q <= wr_mode;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
  end

  assign state      = state_q;
  assign state_next = state_d;
  assign mode       = mode_q;
  assign rd_data    = mem_q[rd_cnt];

endmodule

// File: rtl/stream_bitrev_reorder.sv
// Streaming FFT input reorder: ping-pong frame buffer emitting bit-reversed or natural order.
// Optional BITREV_FRAME_COUNT_EN adds a 16-bit count of completed output frames.
module stream_bitrev_reorder
  import stream_bitrev_reorder_pkg::*;
#(
  parameter int unsigned N = 16,
  localparam int unsigned LOG2N = $clog2(N)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mode_bitrev,
  input  logic             in_valid,
  output logic             in_ready,
  input  complex_product_t in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output complex_product_t out_data,
  output logic [LOG2N-1:0] out_index,
  output logic             out_last
`ifdef BITREV_FRAME_COUNT_EN
  ,
  output logic [15:0]      frame_cnt
`endif
);

  logic             wr_bank_q, wr_bank_d, rd_bank_q;
  logic [LOG2N-1:0] wr_cnt_q, rd_cnt_q;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_last_q;
  complex_product_t out_data_q;
  logic [LOG2N-1:0] out_index_q, rd_index;

  bank_state_t      bank_state [2];
  bank_state_t      bank_state_next [2];
  logic             bank_mode [2];
  complex_product_t bank_rd_data [2];

  logic wr_fire, wr_last, rd_avail, load, rd_last;

  assign wr_fire  = in_valid & in_ready_q;
  assign wr_last  = (wr_cnt_q == LOG2N'(N-1));
  assign rd_last  = (rd_cnt_q == LOG2N'(N-1));
  assign rd_avail = (bank_state[rd_bank_q] == FULL) || (bank_state[rd_bank_q] == DRAINING);
  assign load     = rd_avail && (!out_valid_q || out_ready);
  assign rd_index = bank_mode[rd_bank_q] ? LOG2N'(bitrev(MaxIdxW'(rd_cnt_q), LOG2N)) : rd_cnt_q;

  for (genvar b = 0; b < 2; b++) begin : g_bank
    reorder_bank #(
      .N(N)
    ) u_bank (
      .clk        (clk),
      .reset      (reset),
      .wr_en      (wr_fire && (wr_bank_q == 1'(b))),
      .wr_mode    (mode_bitrev),
      .wr_cnt     (wr_cnt_q),
      .wr_data    (in_data),
      .rd_en      (load && (rd_bank_q == 1'(b))),
      .rd_cnt     (rd_cnt_q),
      .state      (bank_state[b]),
      .state_next (bank_state_next[b]),
      .mode       (bank_mode[b]),
      .rd_data    (bank_rd_data[b])
    );
  end

  // in_ready is registered from the next-cycle state of whichever bank will be written next,
  // so a bank completing or emptying this cycle is reflected without a lost cycle.
  always_comb begin
    wr_bank_d  = wr_bank_q ^ (wr_fire & wr_last);
    in_ready_d = (bank_state_next[wr_bank_d] == EMPTY) ||
                 (bank_state_next[wr_bank_d] == FILLING);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      wr_cnt_q    <= '0;
      rd_cnt_q    <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_index_q <= '0;
      out_last_q  <= 1'b0;
    end else begin
      in_ready_q <= in_ready_d;
      if (wr_fire) begin
        wr_cnt_q  <= wr_cnt_q + LOG2N'(1);
        wr_bank_q <= wr_bank_d;
      end
      if (load) begin
        rd_cnt_q    <= rd_cnt_q + LOG2N'(1);
        if (rd_last) rd_bank_q <= ~rd_bank_q;
        out_valid_q <= 1'b1;
        out_data_q  <= bank_rd_data[rd_bank_q];
        out_index_q <= rd_index;
        out_last_q  <= rd_last;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

`ifdef BITREV_FRAME_COUNT_EN
  logic [15:0] frame_cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame_cnt_q <= '0;
    end else if (out_valid_q && out_ready && out_last_q) begin
      frame_cnt_q <= frame_cnt_q + 16'd1;
    end
  end

  assign frame_cnt = frame_cnt_q;
`endif

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_index = out_index_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_stream_bitrev_reorder.sv
// Self-checking bench for stream_bitrev_reorder against a frame-level reference model.
// Build with BITREV_FRAME_COUNT_EN defined to also exercise frame_cnt.
module tb_stream_bitrev_reorder;
  import stream_bitrev_reorder_pkg::*;

  localparam int N = 16;
  localparam int W = 4;

  logic             clk;
  logic             reset;
  logic             mode_bitrev;
  logic             in_valid;
  logic             in_ready;
  complex_product_t in_data;
  logic             out_valid;
  logic             out_ready;
  complex_product_t out_data;
  logic [W-1:0]     out_index;
  logic             out_last;
`ifdef BITREV_FRAME_COUNT_EN
  logic [15:0]      frame_cnt;
`endif

  stream_bitrev_reorder #(
    .N(N)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .mode_bitrev (mode_bitrev),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_index   (out_index),
    .out_last    (out_last)
`ifdef BITREV_FRAME_COUNT_EN
    ,
    .frame_cnt   (frame_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: collect whole frames, then emit them in the order the rules dictate.
  typedef struct {
    complex_product_t data;
    int               idx;
    bit               last;
  } exp_t;

  exp_t             exp_q[$];
  complex_product_t cur_frame[$];
  bit               cur_mode;
  int               seen_r[$];
  int               n_out = 0;
  int               fcnt_model = 0;
  bit               hold_valid = 0;
  complex_product_t hold_data;
  logic [W-1:0]     hold_index;
  logic             hold_last;
  int               stalls = 0;

  function automatic int rev(input int k);
    int r = 0;
    for (int b = 0; b < W; b++) r = r * 2 + ((k >> b) & 1);
    return r;
  endfunction

  always @(negedge clk) begin
    if (!reset) begin
      exp_q.delete();
      cur_frame.delete();
      hold_valid = 0;
      fcnt_model = 0;
    end else begin
      if (hold_valid) begin
        check("hold_valid", out_valid, 1);
        check("hold_data", out_data, hold_data);
        check("hold_index", out_index, hold_index);
        check("hold_last", out_last, hold_last);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("spurious_out", out_valid, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("out_data", out_data, e.data);
          check("out_index", out_index, e.idx);
          check("out_last", out_last, e.last);
          if (e.last) fcnt_model++;
        end
        seen_r.push_back(int'(out_data.r));
        n_out++;
      end
      hold_valid = out_valid && !out_ready;
      hold_data  = out_data;
      hold_index = out_index;
      hold_last  = out_last;
      if (in_valid && in_ready) begin
        if (cur_frame.size() == 0) cur_mode = mode_bitrev;
        cur_frame.push_back(in_data);
        if (cur_frame.size() == N) begin
          for (int k = 0; k < N; k++) begin
            exp_t e;
            e.idx  = cur_mode ? rev(k) : k;
            e.data = cur_frame[e.idx];
            e.last = (k == N - 1);
            exp_q.push_back(e);
          end
          cur_frame.delete();
        end
      end
    end
  end

  task automatic push(input complex_product_t d, input bit m);
    int guard = 0;
    in_valid    = 1'b1;
    in_data     = d;
    mode_bitrev = m;
    @(negedge clk);
    while (!in_ready && guard < 500) begin
      stalls++;
      guard++;
      @(negedge clk);
    end
    if (guard >= 500) check("in_ready_timeout", in_ready, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int guard = 0;
    while ((exp_q.size() != 0 || out_valid) && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 1000) check("drain_timeout", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  function automatic complex_product_t rnd_sample();
    complex_product_t s;
    s.r = 16'($urandom);
    s.i = 16'($urandom);
    return s;
  endfunction

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1);
  end

  int tbl[16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};
  int n0, acc, lat, gaps, quiet;
  bit done;

  initial begin
    reset = 1'b0; in_valid = 1'b0; in_data = '0; mode_bitrev = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_index", out_index, 0);
    check("rst_out_last", out_last, 0);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Bit-reversed frame with ramp data, then latency and order checks.
    out_ready = 1'b1;
    seen_r.delete();
    for (int i = 0; i < N; i++) push('{r: 16'(i), i: 16'd0}, 1'b1);
    idle();
    check("lat_not_early", out_valid, 0);
    @(posedge clk);
    #1;
    check("lat_first_valid", out_valid, 1);
    check("lat_first_r", out_data.r, 0);
    wait_drain();
    check("bitrev_count", seen_r.size(), N);
    for (int k = 0; k < N && k < seen_r.size(); k++) check("bitrev_seq", seen_r[k], tbl[k]);

    // Natural-order frame.
    seen_r.delete();
    for (int i = 0; i < N; i++) push('{r: 16'(i), i: 16'd0}, 1'b0);
    idle();
    wait_drain();
    for (int k = 0; k < N && k < seen_r.size(); k++) check("natural_seq", seen_r[k], k);

    // Three back-to-back frames at full throughput.
    stalls = 0;
    fork
      begin
        for (int f = 0; f < 3; f++)
          for (int i = 0; i < N; i++) push(rnd_sample(), 1'($urandom_range(0, 1)));
        idle();
      end
      begin
        lat = 0;
        do begin
          @(negedge clk);
          lat++;
        end while (!out_valid && lat < 100);
        check("burst_latency", lat, N + 2);
        gaps = 0;
        repeat (3 * N - 1) begin
          @(negedge clk);
          if (!out_valid) gaps++;
        end
        check("burst_gaps", gaps, 0);
      end
    join
    check("burst_stalls", stalls, 0);
    wait_drain();

    // Backpressure: both banks fill, then release.
    out_ready = 1'b0;
    acc = 0;
    n0 = n_out;
    repeat (40) begin
      in_valid = 1'b1;
      in_data = '{r: 16'(acc), i: 16'(acc + 100)};
      mode_bitrev = 1'b1;
      @(negedge clk);
      if (in_ready) acc++;
      @(posedge clk);
      #1;
    end
    idle();
    check("bp_accepted", acc, 2 * N);
    check("bp_in_ready", in_ready, 0);
    check("bp_out_valid", out_valid, 1);
    check("bp_hold_r", out_data.r, 0);
    out_ready = 1'b1;
    wait_drain();
    check("bp_released", n_out - n0, 2 * N);

    // Mode toggled mid-frame, in both directions.
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < N; i++) push(rnd_sample(), (i < 5) ? 1'(1 - s) : 1'(s));
      for (int i = 0; i < N; i++) push(rnd_sample(), 1'(s));
    end
    idle();
    wait_drain();

    // Random valid gaps, random backpressure, random per-frame mode.
    done = 0;
    fork
      begin
        for (int f = 0; f < 5; f++) begin
          bit m;
          m = 1'($urandom_range(0, 1));
          for (int i = 0; i < N; i++) begin
            if ($urandom_range(0, 3) == 0) begin
              idle();
              @(posedge clk);
              #1;
            end
            push(rnd_sample(), m);
          end
        end
        idle();
        done = 1;
      end
      begin
        while (!done) begin
          out_ready = 1'($urandom_range(0, 2) != 0);
          @(posedge clk);
          #1;
        end
      end
    join
    out_ready = 1'b1;
    wait_drain();
    check("queue_empty_rand", exp_q.size(), 0);

    // Reset while one frame drains and the next is partially written.
    for (int i = 0; i < N + 9; i++) push(rnd_sample(), 1'b1);
    idle();
    check("pre_reset_valid", out_valid, 1);
    #2;
    reset = 1'b0;
    #1;
    check("async_out_valid", out_valid, 0);
    check("async_out_data", out_data, 0);
    check("async_out_index", out_index, 0);
    check("async_out_last", out_last, 0);
    check("async_in_ready", in_ready, 0);
`ifdef BITREV_FRAME_COUNT_EN
    check("async_frame_cnt", frame_cnt, 0);
`endif
    @(posedge clk);
    #1;
    reset = 1'b1;
    n0 = n_out;
    quiet = 0;
    repeat (25) begin
      @(negedge clk);
      if (out_valid) quiet++;
    end
    check("post_reset_quiet", quiet, 0);
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) push(rnd_sample(), 1'b0);
    idle();
    wait_drain();
    check("post_reset_frame", n_out - n0, N);
`ifdef BITREV_FRAME_COUNT_EN
    check("frame_cnt_one", frame_cnt, 1);
    check("frame_cnt_model", frame_cnt, fcnt_model);
`endif

    check("final_queue_empty", exp_q.size(), 0);
    check("final_partial", cur_frame.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
